// File: rtl/port_fifo.sv
// Per-port output queue: buffers words from the address selector in arrival
// order and presents them to egress through a first-word-fall-through
// valid/ready interface. Pushes into a full queue are dropped and counted
// instead of back-pressuring the selector.
module port_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] datain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wrPtr_q, wrPtr_d;
    logic [AW-1:0] rdPtr_q, rdPtr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   dropCnt_q, dropCnt_d;

    logic isFull;
    logic isEmpty;
    logic pop;
    logic accept;
    logic drop;

    // Decode handshake events and next state from registered occupancy only,
    // so a pop in the same cycle frees a slot for a push into a full queue.
    always_comb begin
        isFull     = (count_q == FULL_COUNT);
        isEmpty    = (count_q == '0);
        pop        = !isEmpty && out_ready;
        accept     = push && (!isFull || pop);
        drop       = push && isFull && !pop;

        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        dropCnt_d  = dropCnt_q;

        if (accept) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (dropCnt_q != 16'hFFFF) begin
                dropCnt_d = dropCnt_q + 16'd1;
            end
        end
    end

    // Control state: synchronous active-low reset wins over any push/pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            dropCnt_q  <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            dropCnt_q  <= dropCnt_d;
        end
    end

    // Storage array is never cleared; stale contents are masked by empty.
    always_ff @(posedge clk) begin
        if (reset_n && accept) begin
            mem[wrPtr_q] <= datain;
        end
    end

    // Outputs come from registered state only; head word is zero when empty.
    always_comb begin
        out_valid = !isEmpty;
        dataout   = isEmpty ? '0 : mem[rdPtr_q];
        full      = isFull;
        empty     = isEmpty;
        count     = count_q;
        overflow  = overflow_q;
        drop_cnt  = dropCnt_q;
    end

endmodule

// File: tb/tb_port_fifo.sv
// Scoreboard bench for port_fifo: the stimulus side predicts accepted words
// and pushes them into a queue; a monitor on the falling edge compares the
// presented head word, flags and counters and pops on each handshake.
module tb_port_fifo;

    logic        clk;
    logic        reset_n;
    logic        push;
    logic [31:0] datain;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] dataout;
    logic        full;
    logic        empty;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;

    int checks;
    int errors;

    logic [31:0] sbq[$];
    int          mCount;
    logic [15:0] mDrop;
    logic        mOverflow;

    port_fifo #(.WIDTH(32), .DEPTH(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .datain    (datain),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dataout   (dataout),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: compare the DUT state against the model between edges, then
    // retire the head word when the upcoming edge is a pop.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                checkOutput("count", 32'(count), 32'(mCount));
                checkOutput("full", 32'(full), 32'(mCount == 16));
                checkOutput("empty", 32'(empty), 32'(mCount == 0));
                checkOutput("out_valid", 32'(out_valid), 32'(sbq.size() != 0));
                checkOutput("overflow", 32'(overflow), 32'(mOverflow));
                checkOutput("drop_cnt", 32'(drop_cnt), 32'(mDrop));
                if (sbq.size() != 0) begin
                    checkOutput("dataout", dataout, sbq[0]);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                    end
                end else begin
                    checkOutput("dataout_idle", dataout, 32'h0);
                end
            end
        end
    end

    // Drive one cycle of inputs and advance the reference occupancy model.
    task automatic applyStimulus(input logic p, input logic [31:0] d, input logic r);
        logic mPop;
        logic mFull;
        logic mAcc;
        push      = p;
        datain    = d;
        out_ready = r;
        mPop  = r && (mCount != 0);
        mFull = (mCount == 16);
        mAcc  = p && (!mFull || mPop);
        @(posedge clk);
        #1;
        if (mAcc) begin
            sbq.push_back(d);
        end
        if (p && mFull && !mPop) begin
            mOverflow = 1'b1;
            if (mDrop != 16'hFFFF) begin
                mDrop = mDrop + 16'd1;
            end
        end
        mCount = mCount + int'(mAcc) - int'(mPop);
    endtask

    // Hold reset for a number of edges with a live push and pop request.
    task automatic doReset(input int cycles, input logic [31:0] d);
        reset_n   = 1'b0;
        push      = 1'b1;
        datain    = d;
        out_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        push      = 1'b0;
        out_ready = 1'b0;
        sbq.delete();
        mCount    = 0;
        mDrop     = 16'h0;
        mOverflow = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        mCount    = 0;
        mDrop     = 16'h0;
        mOverflow = 1'b0;
        reset_n   = 1'b0;
        push      = 1'b0;
        datain    = 32'h0;
        out_ready = 1'b0;

        // Reset with a push present: nothing may be enqueued.
        doReset(2, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h0, 1'b0);

        // Fill with 0..F, then three pushes into the full queue are dropped.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hBAD0_0000 + 32'(i), 1'b0);
        checkOutput("drop_cnt_after_overflow", 32'(drop_cnt), 32'd3);
        checkOutput("count_after_overflow", 32'(count), 32'd16);

        // Drain in order, one per cycle.
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("empty_after_drain", 32'(empty), 32'd1);

        // Full queue with simultaneous push and pop for 20 cycles.
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1);
        checkOutput("drop_cnt_no_new_drops", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 17; i++) applyStimulus(1'b0, 32'h0, 1'b1);

        // Streaming: bursts of 5 pushes and 3 pops.
        for (int c = 0; c < 40; c++) begin
            if ((c % 8) < 5) applyStimulus(1'b1, 32'h300 + 32'(c), 1'b0);
            else             applyStimulus(1'b0, 32'h0, 1'b1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        checkOutput("count_before_midreset", 32'(count), 32'd9);

        // Reset mid-operation, then a fresh word must appear next cycle.
        doReset(1, 32'h1234_5678);
        checkOutput("count_after_midreset", 32'(count), 32'd0);
        checkOutput("valid_after_midreset", 32'(out_valid), 32'd0);
        applyStimulus(1'b1, 32'hA5A5A5A5, 1'b0);
        checkOutput("dataout_after_midreset", dataout, 32'hA5A5A5A5);
        applyStimulus(1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
